clock_display_scan: RTL and testbench
=====================================

// Module: clock_display_scan
// PURPOSE
//  Consumer end of the CLOCK time interface: takes binary sec/min/hr/AMPM from CLOCK
//  and drives a 6-digit multiplexed 7-segment display (HH.MM.SS). Snapshots time once
//  per scan frame (no tearing), converts to BCD and scans one digit at a time.
//  Sits between CLOCK and board display pins.
// PARAMETERS
//  SCAN_DIV        4   clk cycles each digit is held (>=2)
//  SEG_ACTIVE_LOW  0   1 = invert seg, dp, digit_sel at the pins
// PORTS
//  clk          in   1  single clock
//  rst          in   1  reset, synchronous, active-high
//  sec          in   6  seconds from CLOCK, valid 0..59
//  min          in   6  minutes from CLOCK, valid 0..59
//  hr           in   5  hours from CLOCK, valid 1..12
//  AMPM         in   1  1 = PM
//  en           in   1  display enable; 0 blanks outputs, scanning continues
//  digit_sel    out  6  one-hot digit strobe, bit0 = leftmost (hr tens)
//  seg          out  7  segments {g,f,e,d,c,b,a}
//  dp           out  1  decimal point of strobed digit
//  frame_start  out  1  1-cycle pulse when a new snapshot is loaded
// BEHAVIOUR (polarities below are active-high, i.e. SEG_ACTIVE_LOW=0)
//  - Reset: div_cnt=0, idx=0, snapshot=0, digit_sel=0, seg=0, dp=0, frame_start=0.
//  - div_cnt counts 0..SCAN_DIV-1; at terminal count idx advances 0..5, wraps 5->0.
//  - Snapshot: sec/min/hr/AMPM captured on first clk edge after rst deasserts and on
//    every idx 5->0 wrap; frame_start=1 in the cycle after capture, else 0.
//    Input changes mid-frame never affect the current frame.
//  - Frame = 6*SCAN_DIV cycles; digit k strobed for exactly SCAN_DIV consecutive cycles.
//  - Outputs registered: digit_sel/seg/dp change 1 cycle after idx/snapshot change;
//    digit 0 strobe begins the cycle frame_start is high.
//  - idx->digit: 0 hr tens, 1 hr ones, 2 min tens, 3 min ones, 4 sec tens, 5 sec ones.
//  - BCD: tens=v/10, ones=v%10 (v<=59, 6-bit; hr 5-bit). No divider: compare/subtract.
//  - hr tens == 0 -> seg=0 (blank), digit_sel[0] still asserted.
//  - Out of range (sec>59, min>59, hr==0, hr>12): both digits of that pair show dash
//    seg=7'b1000000; other pairs unaffected.
//  - dp=1 on idx 1 and 3 (separators); dp=1 on idx 5 iff snapshot AMPM=1; else 0.
//  - Seg codes 0..9: 0111111 0000110 1011011 1001111 1100110 1101101 1111101
//    0000111 1111111 1101111.
//  - en=0: digit_sel=0, seg=0, dp=0 (registered, 1-cycle latency); div_cnt, idx,
//    snapshot and frame_start unaffected.
//  - SEG_ACTIVE_LOW=1: seg, dp, digit_sel inverted at output regs only (reset = all 1s).
//  - rst mid-frame: next cycle all outputs reset values; scan restarts at idx 0 with
//    fresh snapshot on first edge after release.
// TESTING (SCAN_DIV=4, SEG_ACTIVE_LOW=0)
//  - rst=1 3 cycles -> digit_sel=0, seg=0, dp=0, frame_start=0; release -> frame_start
//    pulses once, then again exactly 24 cycles later.
//  - hr=12 min=34 sec=56 AMPM=1 -> per 4-cycle slot digit_sel 000001..100000, seg
//    0000110,1011011,1001111,1100110,1101101,1111101; dp=1 on slots 1,3,5.
//  - hr=9 AMPM=0 -> slot0 digit_sel=000001 seg=0; slot1 seg=1101111 dp=1; slot5 dp=0.
//  - sec 59->0 during slot 2 -> slots 4,5 still 5,9; next frame shows 0,0.
//  - min=60 -> slots 2,3 seg=1000000; hr=0 -> slots 0,1 seg=1000000; sec digits correct.
//  - en=0 for one frame -> outputs 0, frame_start still every 24 cycles; rst in slot 3
//    -> outputs 0 next cycle, restart at slot 0 after release.

Source files
------------

// File: rtl/clock_display_scan.sv
// clock_display_scan
//   Drives a 6-digit multiplexed 7-segment display (HH.MM.SS) from the binary
//   time outputs of CLOCK. The time is captured once per scan frame so a
//   frame never shows a mix of old and new values. Each captured field is
//   converted to BCD, and the digits are strobed one at a time.
//
// Parameters
//   SCAN_DIV        clk cycles each digit is held (>= 2)
//   SEG_ACTIVE_LOW  1 = seg, dp and digit_sel are inverted at the output registers
//
// Ports
//   clk          in   clock
//   rst          in   synchronous reset, active-high
//   sec/min/hr   in   binary time from CLOCK (sec/min 0..59, hr 1..12)
//   AMPM         in   1 = PM
//   en           in   display enable; 0 blanks outputs, scanning continues
//   digit_sel    out  one-hot digit strobe, bit0 = hour tens (leftmost)
//   seg          out  segments {g,f,e,d,c,b,a}
//   dp           out  decimal point of the strobed digit
//   frame_start  out  1-cycle pulse in the first cycle of each displayed frame
module clock_display_scan #(
   parameter int SCAN_DIV       = 4,
   parameter int SEG_ACTIVE_LOW = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] sec,
   input  logic [5:0] min,
   input  logic [4:0] hr,
   input  logic       AMPM,
   input  logic       en,
   output logic [5:0] digit_sel,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_start
);

   localparam int             DW       = $clog2(SCAN_DIV);
   localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic           INV      = (SEG_ACTIVE_LOW != 0);
   localparam logic [6:0]     SEG_DASH = 7'b1000000;

   typedef enum logic [2:0] {
      D_HR_T, D_HR_O, D_MIN_T, D_MIN_O, D_SEC_T, D_SEC_O
   } digit_t;

   logic [DW-1:0] div_cnt;
   digit_t        idx;
   logic [5:0]    snap_sec, snap_min;
   logic [4:0]    snap_hr;
   logic          snap_ampm;
   logic          first;     // first edge after reset: capture without advancing
   logic          live;      // a snapshot has been captured since reset
   logic          load_d;    // capture happened last edge
   logic          tc, load;

   logic [5:0]    dsel_raw;
   logic [6:0]    seg_raw;
   logic          dp_raw;

   // Compare/subtract BCD split; inputs above 59 are flagged out of range
   // elsewhere, so their result is never displayed.
   function automatic logic [7:0] to_bcd(input logic [5:0] v);
      logic [5:0] r;
      logic [3:0] t;
      r = v;
      t = '0;
      for (int unsigned i = 0; i < 5; i++) begin
         if (r >= 6'd10) begin
            r = r - 6'd10;
            t = t + 4'd1;
         end
      end
      return {t, r[3:0]};
   endfunction

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b0111111;
         4'd1:    return 7'b0000110;
         4'd2:    return 7'b1011011;
         4'd3:    return 7'b1001111;
         4'd4:    return 7'b1100110;
         4'd5:    return 7'b1101101;
         4'd6:    return 7'b1111101;
         4'd7:    return 7'b0000111;
         4'd8:    return 7'b1111111;
         4'd9:    return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   always_comb begin
      tc   = (div_cnt == DIV_LAST);
      load = first || (tc && idx == D_SEC_O);
   end

   always_comb begin
      logic [7:0] sec_bcd, min_bcd, hr_bcd;
      logic       sec_bad, min_bad, hr_bad;
      logic [3:0] digit;
      logic       bad, blank;

      sec_bcd = to_bcd(snap_sec);
      min_bcd = to_bcd(snap_min);
      hr_bcd  = to_bcd({1'b0, snap_hr});
      sec_bad = (snap_sec > 6'd59);
      min_bad = (snap_min > 6'd59);
      hr_bad  = (snap_hr == 5'd0) || (snap_hr > 5'd12);

      digit = '0;
      bad   = 1'b0;
      blank = 1'b0;
      case (idx)
         D_HR_T:  begin digit = hr_bcd[7:4];  bad = hr_bad; blank = (hr_bcd[7:4] == 4'd0); end
         D_HR_O:  begin digit = hr_bcd[3:0];  bad = hr_bad;  end
         D_MIN_T: begin digit = min_bcd[7:4]; bad = min_bad; end
         D_MIN_O: begin digit = min_bcd[3:0]; bad = min_bad; end
         D_SEC_T: begin digit = sec_bcd[7:4]; bad = sec_bad; end
         D_SEC_O: begin digit = sec_bcd[3:0]; bad = sec_bad; end
         default: ;
      endcase

      // Dash wins over blanking, so hr==0 shows two dashes.
      seg_raw  = bad ? SEG_DASH : (blank ? 7'b0000000 : seg_code(digit));
      dp_raw   = (idx == D_HR_O) || (idx == D_MIN_O) || (idx == D_SEC_O && snap_ampm);
      dsel_raw = 6'd1 << idx;

      if (!(en && live)) begin
         seg_raw  = '0;
         dp_raw   = 1'b0;
         dsel_raw = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt     <= '0;
         idx         <= D_HR_T;
         snap_sec    <= '0;
         snap_min    <= '0;
         snap_hr     <= '0;
         snap_ampm   <= 1'b0;
         first       <= 1'b1;
         live        <= 1'b0;
         load_d      <= 1'b0;
         frame_start <= 1'b0;
         digit_sel   <= {6{INV}};
         seg         <= {7{INV}};
         dp          <= INV;
      end else begin
         first       <= 1'b0;
         load_d      <= load;
         frame_start <= load_d;

         if (load) begin
            snap_sec  <= sec;
            snap_min  <= min;
            snap_hr   <= hr;
            snap_ampm <= AMPM;
            live      <= 1'b1;
         end

         // Counters hold on the capture edge after reset so digit 0 gets a full slot.
         if (first) begin
            div_cnt <= '0;
            idx     <= D_HR_T;
         end else if (tc) begin
            div_cnt <= '0;
            idx     <= (idx == D_SEC_O) ? D_HR_T : digit_t'(idx + 3'd1);
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end

         digit_sel <= dsel_raw ^ {6{INV}};
         seg       <= seg_raw ^ {7{INV}};
         dp        <= dp_raw ^ INV;
      end
   end

endmodule

// File: tb/tb_clock_display_scan.sv
module tb_clock_display_scan;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] sec, min;
   logic [4:0] hr;
   logic       AMPM, en;
   logic [5:0] digit_sel;
   logic [6:0] seg;
   logic       dp, frame_start;

   int checks   = 0;
   int failures = 0;

   localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011,
                          S3 = 7'b1001111, S4 = 7'b1100110, S5 = 7'b1101101,
                          S6 = 7'b1111101, S7 = 7'b0000111, S9 = 7'b1101111,
                          SD = 7'b1000000, SB = 7'b0000000;

   clock_display_scan #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(0)) dut (
      .clk(clk), .rst(rst), .sec(sec), .min(min), .hr(hr), .AMPM(AMPM), .en(en),
      .digit_sel(digit_sel), .seg(seg), .dp(dp), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0][6:0] pack6(input logic [6:0] a0, a1, a2, a3, a4, a5);
      return {a5, a4, a3, a2, a1, a0};
   endfunction

   task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                           input logic pm);
      hr = h; min = m; sec = s; AMPM = pm;
   endtask

   // Checks one full frame starting at the cycle frame_start is high. The next
   // time is applied mid-frame (slot 2), the next enable at the last cycle.
   task automatic check_frame(input string name, input logic [5:0][6:0] exp_seg,
                              input logic [5:0] exp_dp, input logic exp_en,
                              input logic [4:0] nh, input logic [5:0] nm,
                              input logic [5:0] ns, input logic npm, input logic nen);
      for (int c = 0; c < 24; c++) begin
         int s;
         s = c / 4;
         check_eq($sformatf("%s_fs_c%0d", name, c), frame_start, (c == 0));
         check_eq($sformatf("%s_dsel_c%0d", name, c), digit_sel,
                  exp_en ? (6'd1 << s) : 6'd0);
         check_eq($sformatf("%s_seg_c%0d", name, c), seg, exp_en ? exp_seg[s] : 7'd0);
         check_eq($sformatf("%s_dp_c%0d", name, c), dp, exp_en ? exp_dp[s] : 1'b0);
         if (c == 8)  set_time(nh, nm, ns, npm);
         if (c == 23) en = nen;
         step();
      end
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b1;
      set_time(5'd12, 6'd34, 6'd56, 1'b1);
      repeat (3) step();
      check_eq("rst_dsel", digit_sel, 6'd0);
      check_eq("rst_seg", seg, 7'd0);
      check_eq("rst_dp", dp, 1'b0);
      check_eq("rst_fs", frame_start, 1'b0);

      rst = 1'b0;
      step();   // capture edge
      check_eq("cap_fs", frame_start, 1'b0);
      check_eq("cap_dsel", digit_sel, 6'd0);
      step();

      check_frame("f1", pack6(S1, S2, S3, S4, S5, S6), 6'b101010, 1'b1,
                  5'd9, 6'd34, 6'd59, 1'b0, 1'b1);
      check_frame("f2", pack6(SB, S9, S3, S4, S5, S9), 6'b001010, 1'b1,
                  5'd9, 6'd34, 6'd0, 1'b0, 1'b1);
      check_frame("f3", pack6(SB, S9, S3, S4, S0, S0), 6'b001010, 1'b1,
                  5'd0, 6'd60, 6'd7, 1'b1, 1'b1);
      check_frame("f4", pack6(SD, SD, SD, SD, S0, S7), 6'b101010, 1'b1,
                  5'd12, 6'd34, 6'd56, 1'b1, 1'b0);
      check_frame("f5", pack6(S1, S2, S3, S4, S5, S6), 6'b101010, 1'b0,
                  5'd12, 6'd34, 6'd56, 1'b1, 1'b1);
      check_frame("f6", pack6(S1, S2, S3, S4, S5, S6), 6'b101010, 1'b1,
                  5'd12, 6'd34, 6'd56, 1'b1, 1'b1);

      // Into slot 3 of the next frame, then reset.
      check_eq("f7_fs", frame_start, 1'b1);
      repeat (13) step();
      check_eq("f7_slot3_dsel", digit_sel, 6'b001000);
      rst = 1'b1;
      set_time(5'd1, 6'd5, 6'd9, 1'b0);
      step();
      check_eq("mid_rst_dsel", digit_sel, 6'd0);
      check_eq("mid_rst_seg", seg, 7'd0);
      check_eq("mid_rst_dp", dp, 1'b0);
      check_eq("mid_rst_fs", frame_start, 1'b0);
      step();
      rst = 1'b0;
      step();   // capture edge
      check_eq("recap_fs", frame_start, 1'b0);
      check_eq("recap_dsel", digit_sel, 6'd0);
      step();
      check_frame("f8", pack6(SB, S1, S0, S5, S0, S9), 6'b001010, 1'b1,
                  5'd1, 6'd5, 6'd9, 1'b0, 1'b1);
      check_eq("f9_fs", frame_start, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
